ps2_port: RTL

PS2_PORT -- requirements
Module: ps2_port

---
 rtl/ps2_port.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_port.sv
// PS/2 host port: debounced receiver with scan-code FIFO and host-to-device command transmitter.
// Define PS2_TX_RETRY_EN to retry a failed command up to MAX_RETRIES extra times.
module ps2_port #(
  parameter int unsigned CLK_HZ          = 51_800_000,
  parameter int unsigned DEBOUNCE_CYCLES = 255,
  parameter int unsigned RX_DEPTH        = 4,
  parameter int unsigned WATCHDOG_US     = 1100,
  parameter int unsigned DELAY_US        = 100,
  parameter int unsigned MAX_RETRIES     = 2
) (
  input  logic       clk,
  input  logic       reset_low,
  input  logic       ps2_clk_in,
  output logic       ps2_clk_out,
  output logic       ps2_clk_oe,
  input  logic       ps2_data_in,
  output logic       ps2_data_out,
  output logic       ps2_data_oe,
  output logic       command_ready,
  input  logic       command_valid,
  input  logic [7:0] command_byte,
  input  logic       command_ack_ready,
  output logic       command_ack_valid,
  output logic       command_ack_error,
  input  logic       scan_code_ready,
  output logic       scan_code_valid,
  output logic [7:0] scan_code_byte,
  output logic       scan_code_error,
  output logic       rx_overflow
);

  localparam logic [63:0] WD_CYC64  = (64'(CLK_HZ) * 64'(WATCHDOG_US) + 64'd999_999) / 64'd1_000_000;
  localparam logic [63:0] DLY_CYC64 = (64'(CLK_HZ) * 64'(DELAY_US) + 64'd999_999) / 64'd1_000_000;
  localparam int unsigned WD_CYC  = 32'(WD_CYC64);
  localparam int unsigned DLY_CYC = 32'(DLY_CYC64);
  localparam int unsigned TMR_MAX = (WD_CYC > DLY_CYC) ? WD_CYC : DLY_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PTR_W   = $clog2(RX_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned RTY_W   = $clog2(MAX_RETRIES + 2);
`ifdef PS2_TX_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] RX_DATA    = 4'd1;
  localparam logic [3:0] RX_PARITY  = 4'd2;
  localparam logic [3:0] RX_STOP    = 4'd3;
  localparam logic [3:0] RX_END     = 4'd4;
  localparam logic [3:0] TX_REQUEST = 4'd5;
  localparam logic [3:0] TX_START   = 4'd6;
  localparam logic [3:0] TX_DATA    = 4'd7;
  localparam logic [3:0] TX_PARITY  = 4'd8;
  localparam logic [3:0] TX_STOP    = 4'd9;
  localparam logic [3:0] TX_ACK     = 4'd10;
  localparam logic [3:0] TX_END     = 4'd11;

  assign ps2_clk_out = 1'b0;

  // Line conditioning: index 0 is the PS/2 clock, index 1 the PS/2 data.
  logic [1:0]      raw, meta, sync, filt;
  logic [DB_W-1:0] db_cnt [2];
  logic            clk_prev, fall;

  assign raw = {ps2_data_in, ps2_clk_in};

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      meta      <= 2'b11;
      sync      <= 2'b11;
      filt      <= 2'b11;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
      clk_prev  <= 1'b1;
      fall      <= 1'b0;
    end else begin
      meta     <= raw;
      sync     <= meta;
      clk_prev <= filt[0];
      fall     <= clk_prev & ~filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          filt[i]   <= sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Scan-code FIFO; the head is registered so scan_code_byte needs no read mux at the port.
  logic [7:0]       mem [RX_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n;
  logic [CNT_W-1:0] count, count_n;
  logic [7:0]       head_n;
  logic             fifo_full, pop, push_req_c, push, ovf;
  logic [7:0]       shreg;

  assign fifo_full = (count == CNT_W'(RX_DEPTH));
  assign pop       = scan_code_ready & scan_code_valid;
  assign push      = push_req_c & (~fifo_full | pop);
  assign ovf       = push_req_c & fifo_full & ~pop;

  always_comb begin
    count_n = count;
    if (push && !pop) count_n = count + 1'b1;
    else if (pop && !push) count_n = count - 1'b1;
    rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;
    head_n   = (push && wr_ptr == rd_ptr_n) ? shreg : mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      scan_code_valid <= 1'b0;
      scan_code_byte  <= 8'd0;
      rx_overflow     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr          <= rd_ptr_n;
      count           <= count_n;
      scan_code_valid <= (count_n != '0);
      scan_code_byte  <= head_n;
      rx_overflow     <= ovf;
    end
  end

  // Protocol FSM.
  logic [3:0]       state, state_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg_n, tx_byte, tx_byte_n;
  logic             par, par_n, frame_ok, frame_ok_n, tx_fail, tx_fail_n;
  logic [RTY_W-1:0] retry_cnt, retry_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic             data_oe_n, data_out_n, clk_oe_n, ack_valid_n, ack_error_n;
  logic             rx_err_n, ready_n, wd_on, is_rx, wd_expired, dly_done;

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    par_n       = par;
    frame_ok_n  = frame_ok;
    tx_byte_n   = tx_byte;
    tx_fail_n   = tx_fail;
    retry_n     = retry_cnt;
    data_oe_n   = ps2_data_oe;
    data_out_n  = ps2_data_out;
    ack_valid_n = command_ack_valid;
    ack_error_n = command_ack_error;
    rx_err_n    = 1'b0;
    push_req_c  = 1'b0;
    is_rx       = state inside {RX_DATA, RX_PARITY, RX_STOP};
    wd_on       = is_rx || (state inside {TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_ACK});
    wd_expired  = wd_on && !fall && (tmr == TMR_W'(WD_CYC - 1));
    dly_done    = (tmr == TMR_W'(DLY_CYC - 1));
    if (command_ack_valid && command_ack_ready) ack_valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (command_valid && command_ready) begin
          tx_byte_n  = command_byte;
          tx_fail_n  = 1'b0;
          retry_n    = '0;
          data_oe_n  = 1'b1;
          data_out_n = 1'b0;
          state_n    = TX_REQUEST;
        end else if (fall && !filt[1]) begin
          bit_cnt_n = 3'd0;
          par_n     = 1'b0;
          state_n   = RX_DATA;
        end
      end
      RX_DATA: if (fall) begin
        shreg_n   = {filt[1], shreg[7:1]};
        par_n     = par ^ filt[1];
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_n = RX_PARITY;
      end
      RX_PARITY: if (fall) begin
        frame_ok_n = par ^ filt[1];
        state_n    = RX_STOP;
      end
      RX_STOP: if (fall) begin
        frame_ok_n = frame_ok & filt[1];
        rx_err_n   = ~(frame_ok & filt[1]);
        state_n    = RX_END;
      end
      RX_END: if (dly_done) begin
        push_req_c = frame_ok;
        state_n    = IDLE;
      end
      TX_REQUEST: if (dly_done) state_n = TX_START;
      TX_START: if (fall) begin
        data_out_n = tx_byte[0];
        bit_cnt_n  = 3'd0;
        state_n    = TX_DATA;
      end
      TX_DATA: if (fall) begin
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          data_out_n = ~^tx_byte;
          state_n    = TX_PARITY;
        end else begin
          data_out_n = tx_byte[3'(bit_cnt + 3'd1)];
        end
      end
      TX_PARITY: if (fall) begin
        data_oe_n = 1'b0;
        state_n   = TX_STOP;
      end
      TX_STOP: if (fall) begin
        tx_fail_n = filt[1];
        state_n   = TX_ACK;
      end
      TX_ACK: if (filt[0]) state_n = TX_END;
      TX_END: if (dly_done) begin
        if (tx_fail && RETRY_EN && retry_cnt != RTY_W'(MAX_RETRIES)) begin
          retry_n    = retry_cnt + 1'b1;
          tx_fail_n  = 1'b0;
          data_oe_n  = 1'b1;
          data_out_n = 1'b0;
          state_n    = TX_REQUEST;
        end else begin
          ack_valid_n = 1'b1;
          ack_error_n = tx_fail;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // A stalled device aborts RX outright; in TX it counts as a failed attempt.
    if (wd_expired) begin
      if (is_rx) begin
        rx_err_n = 1'b1;
        state_n  = IDLE;
      end else begin
        tx_fail_n = 1'b1;
        data_oe_n = 1'b0;
        state_n   = TX_END;
      end
    end

    tmr_n    = (state_n != state || fall || state == IDLE) ? '0 : tmr + 1'b1;
    clk_oe_n = (state_n == TX_REQUEST) || (state_n == IDLE && fifo_full);
    ready_n  = (state_n == IDLE) && !ack_valid_n;
  end

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state             <= IDLE;
      bit_cnt           <= 3'd0;
      shreg             <= 8'd0;
      par               <= 1'b0;
      frame_ok          <= 1'b0;
      tx_byte           <= 8'd0;
      tx_fail           <= 1'b0;
      retry_cnt         <= '0;
      tmr               <= '0;
      ps2_clk_oe        <= 1'b0;
      ps2_data_oe       <= 1'b0;
      ps2_data_out      <= 1'b0;
      command_ready     <= 1'b0;
      command_ack_valid <= 1'b0;
      command_ack_error <= 1'b0;
      scan_code_error   <= 1'b0;
    end else begin
      state             <= state_n;
      bit_cnt           <= bit_cnt_n;
      shreg             <= shreg_n;
      par               <= par_n;
      frame_ok          <= frame_ok_n;
      tx_byte           <= tx_byte_n;
      tx_fail           <= tx_fail_n;
      retry_cnt         <= retry_n;
      tmr               <= tmr_n;
      ps2_clk_oe        <= clk_oe_n;
      ps2_data_oe       <= data_oe_n;
      ps2_data_out      <= data_out_n;
      command_ready     <= ready_n;
      command_ack_valid <= ack_valid_n;
      command_ack_error <= ack_error_n;
      scan_code_error   <= rx_err_n;
    end
  end

endmodule
